// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Provides the 32-bit word type, PC step/alignment constants and the
// {pc, instr} packet handed from fetch to decode.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t PC_STEP         = 32'd4;
  localparam word_t INSTR_NOP       = 32'h0000_0013;
  localparam word_t WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_packet_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a stalled fetch packet.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   flush_i        discard any held entry (highest priority)
//   load_i/data_i  capture a packet that decode could not accept
//   drain_i        held entry is consumed this cycle
//   valid_o/data_o held entry
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter type T = fetch_packet_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic load_i,
  input  T     data_i,
  input  logic drain_i,
  output logic valid_o,
  output T     data_o
);

  logic valid_q, valid_d;
  T     data_q, data_d;

  // Next entry: flush beats load, load beats drain (load only occurs when empty).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: drives the ROM address, pairs returned words with their
// PC, and streams {pc, instr} packets to decode over valid/ready. Stalls are
// absorbed by a one-entry skid buffer; redirects flush everything in flight.
// Ports:
//   clock, reset              clock, asynchronous active-high reset
//   rom_addr / rom_r_data     ROM request (word aligned) / data one cycle later
//   redirect_valid/_pc        restart fetch at a new address
//   out_valid/out_ready       packet handshake towards decode
//   out_pc/out_instr          presented packet (zero when out_valid=0)
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] rom_addr,
  input  logic [XLEN-1:0] rom_r_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  word_t         pc_q, pc_d;
  word_t         infl_pc_q, infl_pc_d;
  logic          infl_valid_q, infl_valid_d;
  logic          skid_valid;
  fetch_packet_t skid_pkt;
  fetch_packet_t infl_pkt;
  fetch_packet_t out_pkt;
  logic          issue_en;
  logic          stall_capture;
  logic          skid_drain;

  // The in-flight address pairs with whatever the ROM returns this cycle.
  assign infl_pkt = '{pc: infl_pc_q, instr: rom_r_data};

  // Output select: held packet first, then the live ROM response.
  always_comb begin
    out_valid = 1'b0;
    out_pkt   = '0;
    if (!redirect_valid) begin
      if (skid_valid) begin
        out_valid = 1'b1;
        out_pkt   = skid_pkt;
      end else if (infl_valid_q) begin
        out_valid = 1'b1;
        out_pkt   = infl_pkt;
      end
    end
  end

  assign out_pc    = out_pkt.pc;
  assign out_instr = out_pkt.instr;

  // Issue only when nothing is held and the presented packet is not blocked;
  // this leaves one bubble after every drained stall.
  assign issue_en      = !skid_valid && !(out_valid && !out_ready) && !redirect_valid;
  assign stall_capture = infl_valid_q && !skid_valid && !out_ready && !redirect_valid;
  assign skid_drain    = skid_valid && out_ready;

  fetch_skid_buffer #(
    .T (fetch_packet_t)
  ) u_skid (
    .clk_i   (clock),
    .rst_i   (reset),
    .flush_i (redirect_valid),
    .load_i  (stall_capture),
    .data_i  (infl_pkt),
    .drain_i (skid_drain),
    .valid_o (skid_valid),
    .data_o  (skid_pkt)
  );

  // PC sequencing: redirect wins, otherwise advance on issue (wraps silently).
  always_comb begin
    pc_d         = pc_q;
    infl_valid_d = 1'b0;
    infl_pc_d    = infl_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & WORD_ALIGN_MASK;
    end else if (issue_en) begin
      infl_valid_d = 1'b1;
      infl_pc_d    = pc_q;
      pc_d         = pc_q + PC_STEP;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC & WORD_ALIGN_MASK;
      infl_valid_q <= 1'b0;
      infl_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      infl_valid_q <= infl_valid_d;
      infl_pc_q    <= infl_pc_d;
    end
  end

  assign rom_addr = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized ready/redirect
// traffic, checked every cycle against a stream-level reference model.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam word_t RST_PC_A = 32'h0000_0000;
  localparam word_t RST_PC_B = 32'hFFFF_FFF8;

  logic  clock = 1'b0;
  logic  reset;
  word_t rom_addr_a, rom_data_a;
  logic  redirect_valid;
  word_t redirect_pc;
  logic  out_valid;
  logic  out_ready;
  word_t out_pc, out_instr;

  word_t rom_addr_b, rom_data_b;
  logic  out_valid_b;
  word_t out_pc_b, out_instr_b;
  logic  ready_b = 1'b1;
  logic  redir_b = 1'b0;
  word_t redir_pc_b = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_accept = 0;

  always #5 clock = ~clock;

  // ROM contents: word i holds A000_0000 + i.
  function automatic word_t rom_word(input word_t a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  always @(posedge clock) rom_data_a <= rom_word(rom_addr_a);
  always @(posedge clock) rom_data_b <= rom_word(rom_addr_b);

  instr_fetch #(.RESET_PC(RST_PC_A)) dut (
    .clock          (clock),
    .reset          (reset),
    .rom_addr       (rom_addr_a),
    .rom_r_data     (rom_data_a),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  instr_fetch #(.RESET_PC(RST_PC_B)) dut_b (
    .clock          (clock),
    .reset          (reset),
    .rom_addr       (rom_addr_b),
    .rom_r_data     (rom_data_b),
    .redirect_valid (redir_b),
    .redirect_pc    (redir_pc_b),
    .out_valid      (out_valid_b),
    .out_ready      (ready_b),
    .out_pc         (out_pc_b),
    .out_instr      (out_instr_b)
  );

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: head = next pc to present, gap = invisible cycles left,
  // stalled = head was refused at least once (costs one bubble when taken).
  word_t m_head = RST_PC_A;
  int    m_gap = 1;
  bit    m_stalled = 1'b0;
  word_t sb_next = RST_PC_A;

  always @(negedge clock) begin
    if (reset) begin
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_pc", out_pc, 32'h0);
      check("rst_instr", out_instr, 32'h0);
      m_head = RST_PC_A; m_gap = 1; m_stalled = 1'b0; sb_next = RST_PC_A;
    end else begin
      bit vis;
      vis = (m_gap == 0) && !redirect_valid;
      check("mdl_valid", 32'(out_valid), 32'(vis));
      check("mdl_pc", out_pc, vis ? m_head : 32'h0);
      check("mdl_instr", out_instr, vis ? rom_word(m_head) : 32'h0);
      // Ordering scoreboard on accepted packets.
      if (out_valid && out_ready) begin
        check("sb_pc", out_pc, sb_next);
        check("sb_instr", out_instr, rom_word(out_pc));
        sb_next = out_pc + 32'd4;
        n_accept++;
      end
      if (redirect_valid) sb_next = redirect_pc & 32'hFFFF_FFFC;
      // Advance the model to the next cycle.
      if (redirect_valid) begin
        m_head = redirect_pc & 32'hFFFF_FFFC; m_gap = 1; m_stalled = 1'b0;
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (out_ready) begin
        m_head = m_head + 32'd4; m_gap = m_stalled ? 1 : 0; m_stalled = 1'b0;
      end else begin
        m_stalled = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int bubbles;
    reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("c0_valid", 32'(out_valid), 32'h0);
    check("c0_valid_b", 32'(out_valid_b), 32'h0);

    // First packets and wrap-around on the second instance.
    step(); #1;
    check("c1_pc", out_pc, 32'h0);
    check("c1_instr", out_instr, 32'hA000_0000);
    check("wrap_pc0", out_pc_b, 32'hFFFF_FFF8);
    check("wrap_instr0", out_instr_b, 32'hDFFF_FFFE);
    step(); #1;
    check("c2_pc", out_pc, 32'h4);
    check("wrap_pc1", out_pc_b, 32'hFFFF_FFFC);

    // Stall on pc=8 for three cycles.
    step(); out_ready = 1'b0; #1;
    check("stall_pc_a", out_pc, 32'h8);
    check("stall_instr_a", out_instr, 32'hA000_0002);
    check("wrap_pc2", out_pc_b, 32'h0);
    step(); #1;
    check("stall_pc_b", out_pc, 32'h8);
    check("wrap_pc3", out_pc_b, 32'h4);
    check("wrap_instr3", out_instr_b, 32'hA000_0001);
    step(); #1;
    check("stall_valid_c", 32'(out_valid), 32'h1);
    check("stall_instr_c", out_instr, 32'hA000_0002);
    step(); out_ready = 1'b1; #1;
    check("drain_pc", out_pc, 32'h8);
    step(); #1;
    check("bubble_valid", 32'(out_valid), 32'h0);
    step(); #1;
    check("after_bubble_pc", out_pc, 32'hC);

    // Steady streaming, no bubbles.
    bubbles = 0;
    for (int i = 0; i < 100; i++) begin
      step(); #1;
      if (!out_valid) bubbles++;
    end
    check("stream_bubbles", 32'(bubbles), 32'h0);
    check("stream_pc", out_pc, 32'h19C);

    // Redirect while the skid buffer is full.
    step(); out_ready = 1'b0; #1;
    step(); #1;
    check("skid_full_valid", 32'(out_valid), 32'h1);
    step(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    check("redir_valid0", 32'(out_valid), 32'h0);
    step(); redirect_valid = 1'b0; out_ready = 1'b1; #1;
    check("redir_valid1", 32'(out_valid), 32'h0);
    step(); #1;
    check("redir_pc", out_pc, 32'h40);
    check("redir_instr", out_instr, 32'hA000_0010);
    step(); #1;
    check("redir_pc_next", out_pc, 32'h44);

    // Misaligned redirect target.
    step(); redirect_valid = 1'b1; redirect_pc = 32'h43; #1;
    step(); redirect_valid = 1'b0; #1;
    check("align_rom_addr", rom_addr_a, 32'h40);
    step(); #1;
    check("align_pc", out_pc, 32'h40);

    // Reset asserted during a stall.
    step(); out_ready = 1'b0; #1;
    step(); #1;
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    step(); step(); reset = 1'b0; out_ready = 1'b1; #1;
    check("rerst_c0_valid", 32'(out_valid), 32'h0);
    step(); #1;
    check("rerst_pc", out_pc, RST_PC_A);

    // Randomized ready/redirect traffic.
    n_accept = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ?
                       (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
    end
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("random_accepts", 32'(n_accept > 100), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
